counter_bus_ctrl: RTL and testbench

Bus-side controller for the quadrature counter bank: decodes the host's multiplexed address/data bus (ale, rd, wr, ad) and sequences reads and writes against NC free-running counters. It makes 16-bit counter reads atomic across two byte accesses with a high-byte hold register, and it issues per-counter clear pulses. It sits between the counter datapath and the 8-bit host bus pins.

---
 rtl/counter_bus_pkg.sv | 24 ++
 rtl/counter_bus_sample.sv | 56 +++++
 rtl/counter_bus_ctrl.sv | 169 ++++++++++++++++
 tb/tb_counter_bus_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_bus_pkg.sv
// Shared encodings, address constants and byte helper for the counter bus controller.
package counter_bus_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ADDR  = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_WRITE = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    ADDR  = ST_ADDR,
    READ  = ST_READ,
    WRITE = ST_WRITE
  } state_t;

  localparam logic [7:0] CTRL_ADDR_DEF = 8'h10;
  localparam logic [7:0] SNAP_ADDR     = 8'h00;
  localparam logic [7:0] UNMAPPED_DATA = 8'h00;

  function automatic logic [7:0] byte_sel(input logic [15:0] word, input logic hi);
    return hi ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/counter_bus_sample.sv
// Registers the host bus pins once per clock and flags rd/wr strobe edges.
module counter_bus_sample
  import counter_bus_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ale,
  input  logic       i_rd,
  input  logic       i_wr,
  input  logic [7:0] i_ad,
  output logic       o_ale,
  output logic       o_rd,
  output logic       o_wr,
  output logic [7:0] o_ad,
  output logic       o_rd_fall,
  output logic       o_rd_rise,
  output logic       o_wr_fall,
  output logic       o_wr_rise
);

  logic       r_ale;
  logic       r_rd;
  logic       r_wr;
  logic [7:0] r_ad;
  logic       r_rd_d;
  logic       r_wr_d;

  // Strobes are active low, so their idle (reset) level is 1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ale  <= 1'b0;
      r_rd   <= 1'b1;
      r_wr   <= 1'b1;
      r_ad   <= '0;
      r_rd_d <= 1'b1;
      r_wr_d <= 1'b1;
    end else begin
      r_ale  <= i_ale;
      r_rd   <= i_rd;
      r_wr   <= i_wr;
      r_ad   <= i_ad;
      r_rd_d <= r_rd;
      r_wr_d <= r_wr;
    end
  end

  assign o_ale     = r_ale;
  assign o_rd      = r_rd;
  assign o_wr      = r_wr;
  assign o_ad      = r_ad;
  assign o_rd_fall = ~r_rd & r_rd_d;
  assign o_rd_rise = r_rd & ~r_rd_d;
  assign o_wr_fall = ~r_wr & r_wr_d;
  assign o_wr_rise = r_wr & ~r_wr_d;

endmodule

// File: rtl/counter_bus_ctrl.sv
// Host bus controller for the counter bank: atomic 16-bit reads via hold register, clear pulses.
// Optional COUNTER_BUS_SNAPSHOT_ALL_EN: a read of address 0 snapshots every high byte.
//
// state | meaning
// IDLE  | bus quiet, waiting for ale, rd or wr
// ADDR  | ale high, latching address from ad
// READ  | driving ad with the byte loaded on entry
// WRITE | capturing write data until wr rises
module counter_bus_ctrl
  import counter_bus_pkg::*;
#(
  parameter int         NC        = 4,
  parameter int         CW        = 16,
  parameter logic [7:0] CTRL_ADDR = CTRL_ADDR_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NC*CW-1:0] i_cnt,
  input  logic             i_ale,
  input  logic             i_rd,
  input  logic             i_wr,
  inout  wire  [7:0]       io_ad,
  output logic [NC-1:0]    o_clr
);

  localparam logic [3:0] NC_ID = 4'(NC);

  logic          w_s_ale, w_s_rd, w_s_wr;
  logic [7:0]    w_s_ad;
  logic          w_rd_fall, w_rd_rise, w_wr_fall, w_wr_rise;
  state_t        r_state, w_next;
  logic [7:0]    r_addr;
  logic [NC-1:0] r_wdata;
  logic [7:0]    r_rdata;
  logic [NC-1:0] r_clr;
  logic          r_wr_block;
  logic [2:0]    w_idx;
  logic          w_mapped;
  logic          w_ctrl;
  logic [CW-1:0] w_word;
  logic [7:0]    w_hi_byte;
  logic [3:0]    w_tag_rd;
  logic [7:0]    w_rdata_nxt;
  logic          w_rd_entry;
  logic          w_abort_wr;

  counter_bus_sample u_sample (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ale     (i_ale),
    .i_rd      (i_rd),
    .i_wr      (i_wr),
    .i_ad      (io_ad),
    .o_ale     (w_s_ale),
    .o_rd      (w_s_rd),
    .o_wr      (w_s_wr),
    .o_ad      (w_s_ad),
    .o_rd_fall (w_rd_fall),
    .o_rd_rise (w_rd_rise),
    .o_wr_fall (w_wr_fall),
    .o_wr_rise (w_wr_rise)
  );

  assign w_idx    = r_addr[3:1];
  assign w_mapped = r_addr < 8'(2 * NC);
  assign w_ctrl   = r_addr == CTRL_ADDR;

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NC; k++) begin
      if (w_idx == 3'(k)) w_word = i_cnt[k*CW +: CW];
    end
  end

`ifdef COUNTER_BUS_SNAPSHOT_ALL_EN
  logic [7:0] r_hold [NC];

  always_comb begin
    w_hi_byte = '0;
    for (int k = 0; k < NC; k++) begin
      if (w_idx == 3'(k)) w_hi_byte = r_hold[k];
    end
  end
  assign w_tag_rd = 4'h0;
`else
  logic [7:0] r_hold;
  logic [3:0] r_hold_tag;

  assign w_hi_byte = (r_hold_tag == {1'b0, w_idx}) ? r_hold : byte_sel(w_word, 1'b1);
  assign w_tag_rd  = r_hold_tag;
`endif

  always_comb begin
    w_rdata_nxt = UNMAPPED_DATA;
    if (w_ctrl) w_rdata_nxt = {w_tag_rd, NC_ID};
    else if (w_mapped) w_rdata_nxt = r_addr[0] ? w_hi_byte : byte_sel(w_word, 1'b0);
  end

  // Strobe edges are sufficient for exits: a state is only held while its strobe stays low.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_s_ale) w_next = ADDR;
        else if (!w_s_rd) w_next = READ;
        else if (!w_s_wr && !r_wr_block) w_next = WRITE;
      end
      ADDR:  if (!w_s_ale) w_next = IDLE;
      READ: begin
        if (w_s_ale) w_next = ADDR;
        else if (w_rd_rise) w_next = IDLE;
      end
      WRITE: begin
        if (w_s_ale) w_next = ADDR;
        else if (w_wr_rise) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_rd_entry = (r_state == IDLE) && (w_next == READ);
  assign w_abort_wr = (r_state == WRITE) && w_s_ale;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_clr      <= '0;
      r_wr_block <= 1'b0;
    end else begin
      r_state <= w_next;
      r_clr   <= '0;
      if (r_state == ADDR && w_s_ale) r_addr <= w_s_ad;
      if (r_state == WRITE && !w_s_wr) r_wdata <= w_s_ad[NC-1:0];
      if (r_state == WRITE && !w_s_ale && w_wr_rise && w_ctrl) r_clr <= r_wdata;
      if (w_rd_entry) r_rdata <= w_rdata_nxt;
      // A write overlapped by a read, or aborted by ale, stays dead until both strobes idle.
      if (w_s_rd && w_s_wr) r_wr_block <= 1'b0;
      else if ((w_rd_fall && !w_s_wr) || (w_wr_fall && !w_s_rd) || w_abort_wr)
        r_wr_block <= 1'b1;
    end
  end

`ifdef COUNTER_BUS_SNAPSHOT_ALL_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < NC; k++) r_hold[k] <= '0;
    end else if (w_rd_entry && r_addr == SNAP_ADDR) begin
      for (int k = 0; k < NC; k++) r_hold[k] <= i_cnt[k*CW+8 +: 8];
    end
  end
`else
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hold     <= '0;
      r_hold_tag <= '0;
    end else if (w_rd_entry && w_mapped && !r_addr[0]) begin
      r_hold     <= byte_sel(w_word, 1'b1);
      r_hold_tag <= {1'b0, w_idx};
    end
  end
`endif

  assign io_ad = (r_state == READ) ? r_rdata : 8'hzz;
  assign o_clr = r_clr;

endmodule

// File: tb/tb_counter_bus_ctrl.sv
// Directed bench for counter_bus_ctrl; a released ad bus reads 8'hFF through the pull-ups.
module tb_counter_bus_ctrl;

`ifdef COUNTER_BUS_SNAPSHOT_ALL_EN
  localparam bit SNAP = 1'b1;
`else
  localparam bit SNAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ale, rd, wr;
  logic [63:0] cnt;
  wire  [7:0]  ad;
  logic [7:0]  drv;
  logic        drv_en;
  logic [3:0]  clr;
  int          errors = 0;
  int          checks = 0;

  assign ad = drv_en ? drv : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pull
    pullup (ad[g]);
  end

  always #5 clk = ~clk;

  counter_bus_ctrl #(.NC(4), .CW(16), .CTRL_ADDR(8'h10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_cnt (cnt),
    .i_ale (ale),
    .i_rd  (rd),
    .i_wr  (wr),
    .io_ad (ad),
    .o_clr (clr)
  );

  task automatic set_cnt(input int k, input logic [15:0] v);
    cnt[k*16 +: 16] = v;
  endtask

  task automatic do_addr(input logic [7:0] a);
    @(negedge clk);
    ale = 1'b1; drv = a; drv_en = 1'b1;
    repeat (3) @(negedge clk);
    ale = 1'b0;
    repeat (3) @(negedge clk);
    drv_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input bit use_ale, output logic [7:0] d);
    if (use_ale) do_addr(a);
    @(negedge clk);
    rd = 1'b0;
    repeat (2) @(negedge clk);
    d  = ad;
    rd = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          output logic [3:0] c1, output logic [3:0] c2, output logic [3:0] c3);
    do_addr(a);
    @(negedge clk);
    drv = d; drv_en = 1'b1; wr = 1'b0;
    repeat (3) @(negedge clk);
    wr = 1'b1;
    @(negedge clk); c1 = clr;
    @(negedge clk); c2 = clr;
    @(negedge clk); c3 = clr;
    drv_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [7:0] d;
    rst = 1'b1; ale = 1'b0; rd = 1'b1; wr = 1'b1; drv = '0; drv_en = 1'b0; cnt = '0;
    repeat (3) @(negedge clk);
    checks++; if (ad !== 8'hFF) begin errors++; $display("FAIL reset_ad: got %h want ff (released)", ad); end
    checks++; if (clr !== 4'h0) begin errors++; $display("FAIL reset_clr: got %h want 0", clr); end
    rst = 1'b0;
    @(negedge clk);
    set_cnt(0, 16'h3C5A);
    do_read(8'h00, 1'b0, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL reset_addr: got %h want 5a", d); end
    do_read(8'h10, 1'b1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL reset_ctrl: got %h want 04", d); end
  endtask

  task automatic test_atomic();
    logic [7:0] d;
    set_cnt(0, 16'h12FF);
    do_read(8'h00, 1'b1, d);
    checks++; if (d !== 8'hFF) begin errors++; $display("FAIL atomic_lo: got %h want ff", d); end
    set_cnt(0, 16'h1300);
    do_read(8'h01, 1'b1, d);
    checks++; if (d !== 8'h12) begin errors++; $display("FAIL atomic_hi: got %h want 12", d); end
  endtask

  task automatic test_tag_mismatch();
    logic [7:0] d, exp_hi;
    exp_hi = SNAP ? 8'h77 : 8'hA5;
    set_cnt(1, 16'h7700);
    do_read(8'h00, 1'b1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL tag_lo: got %h want 00", d); end
    set_cnt(1, 16'hA55A);
    do_read(8'h03, 1'b1, d);
    checks++; if (d !== exp_hi) begin errors++; $display("FAIL tag_hi: got %h want %h", d, exp_hi); end
    do_read(8'h10, 1'b1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL tag_ctrl: got %h want 04", d); end
  endtask

  task automatic test_latency();
    logic [7:0] d, exp_ctrl;
    exp_ctrl = SNAP ? 8'h04 : 8'h24;
    set_cnt(2, 16'h0042);
    do_addr(8'h04);
    @(negedge clk); rd = 1'b0;
    @(negedge clk);
    checks++; if (ad !== 8'hFF) begin errors++; $display("FAIL lat_early: got %h want ff", ad); end
    @(negedge clk);
    checks++; if (ad !== 8'h42) begin errors++; $display("FAIL lat_data: got %h want 42", ad); end
    set_cnt(2, 16'h0099);
    @(negedge clk);
    checks++; if (ad !== 8'h42) begin errors++; $display("FAIL lat_sample: got %h want 42", ad); end
    rd = 1'b1;
    @(negedge clk);
    checks++; if (ad !== 8'h42) begin errors++; $display("FAIL lat_hold: got %h want 42", ad); end
    @(negedge clk);
    checks++; if (ad !== 8'hFF) begin errors++; $display("FAIL lat_release: got %h want ff", ad); end
    @(negedge clk);
    do_read(8'h10, 1'b1, d);
    checks++; if (d !== exp_ctrl) begin errors++; $display("FAIL lat_ctrl: got %h want %h", d, exp_ctrl); end
  endtask

  task automatic test_clear_write();
    logic [3:0] c1, c2, c3;
    logic [7:0] d;
    do_write(8'h10, 8'h05, c1, c2, c3);
    checks++; if (c1 !== 4'h0) begin errors++; $display("FAIL clr_pre: got %h want 0", c1); end
    checks++; if (c2 !== 4'h5) begin errors++; $display("FAIL clr_pulse: got %h want 5", c2); end
    checks++; if (c3 !== 4'h0) begin errors++; $display("FAIL clr_post: got %h want 0", c3); end
    do_write(8'h10, 8'hF3, c1, c2, c3);
    checks++; if (c2 !== 4'h3) begin errors++; $display("FAIL clr_mask: got %h want 3", c2); end
    do_write(8'h20, 8'h0F, c1, c2, c3);
    checks++; if ((c1 | c2 | c3) !== 4'h0) begin errors++; $display("FAIL clr_unmapped: got %h want 0", c1 | c2 | c3); end
    do_read(8'h20, 1'b1, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL rd_unmapped: got %h want 00", d); end
  endtask

  task automatic test_abort();
    logic [3:0] acc;
    logic [7:0] d;
    acc = '0;
    do_addr(8'h10);
    @(negedge clk);
    drv = 8'h05; drv_en = 1'b1; wr = 1'b0;
    repeat (3) begin @(negedge clk); acc |= clr; end
    ale = 1'b1; drv = 8'h0F;
    repeat (3) begin @(negedge clk); acc |= clr; end
    wr = 1'b1;
    repeat (2) begin @(negedge clk); acc |= clr; end
    ale = 1'b0;
    repeat (4) begin @(negedge clk); acc |= clr; end
    drv_en = 1'b0;
    checks++; if (acc !== 4'h0) begin errors++; $display("FAIL abort_no_clr: got %h want 0", acc); end
    do_read(8'h00, 1'b0, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL abort_addr: got %h want 00 (addr 0f)", d); end
  endtask

  task automatic test_rd_wr_together();
    logic [3:0] acc;
    logic [7:0] d, exp_ctrl;
    exp_ctrl = SNAP ? 8'h04 : 8'h24;
    acc = '0;
    do_addr(8'h10);
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
    d  = ad;
    rd = 1'b1;
    checks++; if (d !== exp_ctrl) begin errors++; $display("FAIL rdwr_data: got %h want %h", d, exp_ctrl); end
    repeat (2) begin @(negedge clk); acc |= clr; end
    drv = 8'h0F; drv_en = 1'b1;
    repeat (4) begin @(negedge clk); acc |= clr; end
    wr = 1'b1;
    repeat (3) begin @(negedge clk); acc |= clr; end
    drv_en = 1'b0;
    checks++; if (acc !== 4'h0) begin errors++; $display("FAIL rdwr_no_clr: got %h want 0", acc); end
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] d, exp_pre;
    exp_pre = SNAP ? 8'h04 : 8'h14;
    do_read(8'h02, 1'b1, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL rst_lo1: got %h want 5a", d); end
    do_addr(8'h10);
    @(negedge clk); rd = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ad !== exp_pre) begin errors++; $display("FAIL rst_pre: got %h want %h", ad, exp_pre); end
    rst = 1'b1; rd = 1'b1;
    @(negedge clk);
    checks++; if (ad !== 8'hFF) begin errors++; $display("FAIL rst_ad: got %h want ff (released)", ad); end
    checks++; if (clr !== 4'h0) begin errors++; $display("FAIL rst_clr: got %h want 0", clr); end
    rst = 1'b0;
    @(negedge clk);
    do_read(8'h10, 1'b1, d);
    checks++; if (d !== 8'h04) begin errors++; $display("FAIL rst_tag: got %h want 04", d); end
  endtask

`ifdef COUNTER_BUS_SNAPSHOT_ALL_EN
  task automatic test_snapshot();
    logic [7:0] d;
    set_cnt(1, 16'h1111); set_cnt(2, 16'h2222); set_cnt(3, 16'h3333);
    do_read(8'h00, 1'b1, d);
    set_cnt(0, 16'hBEEF); set_cnt(1, 16'hAAAA); set_cnt(2, 16'hBBBB); set_cnt(3, 16'hCCCC);
    do_read(8'h03, 1'b1, d);
    checks++; if (d !== 8'h11) begin errors++; $display("FAIL snap_1: got %h want 11", d); end
    do_read(8'h05, 1'b1, d);
    checks++; if (d !== 8'h22) begin errors++; $display("FAIL snap_2: got %h want 22", d); end
    do_read(8'h07, 1'b1, d);
    checks++; if (d !== 8'h33) begin errors++; $display("FAIL snap_3: got %h want 33", d); end
  endtask
`endif

  initial begin
    test_reset();
    test_atomic();
    test_tag_mismatch();
    test_latency();
    test_clear_write();
    test_abort();
    test_rd_wr_together();
    test_reset_mid_read();
`ifdef COUNTER_BUS_SNAPSHOT_ALL_EN
    test_snapshot();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
